onehot_grant_decoder: RTL and testbench

Registered decoder that turns a binary priority code plus valid back into a one-hot grant vector, holding each grant for a fixed number of cycles. It sits downstream of the 4-input priority encoder: the encoder's out/valid pair drives this block's code/valid inputs, and the one-hot output drives the per-requester grant lines. A valid/ready handshake throttles the encoder side while a grant is being held.

---
 rtl/onehot_grant_decoder.sv | 97 +++++++++
 tb/tb_onehot_grant_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/onehot_grant_decoder.sv
// Registered binary-to-one-hot grant decoder. Each accepted code drives one
// grant line for HOLD cycles; in_ready throttles the upstream encoder meanwhile.
module onehot_grant_decoder #(
  parameter int IN_W = 2,
  parameter int HOLD = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_W-1:0]      in_code,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [2**IN_W-1:0]   out_onehot,
  output logic                 out_valid,
  output logic [7:0]           grant_cnt
);

  localparam int OUT_W = 2**IN_W;

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic [OUT_W-1:0] r_onehot, w_onehot_nxt;
  logic             r_valid, w_valid_nxt;
  logic [7:0]       r_grant_cnt, w_grant_cnt_nxt;
  logic [OUT_W-1:0] w_dec;

  assign w_dec = OUT_W'(1) << in_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_onehot    <= '0;
      r_valid     <= 1'b0;
      r_grant_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_onehot    <= w_onehot_nxt;
      r_valid     <= w_valid_nxt;
      r_grant_cnt <= w_grant_cnt_nxt;
    end
  end

  // Flush takes priority over both acceptance and hold countdown.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_onehot_nxt    = r_onehot;
    w_valid_nxt     = r_valid;
    w_grant_cnt_nxt = r_grant_cnt;
    if (flush) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = '0;
      w_onehot_nxt = '0;
      w_valid_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_state_nxt     = S_HOLD;
            w_cnt_nxt       = 8'(HOLD - 1);
            w_onehot_nxt    = w_dec;
            w_valid_nxt     = 1'b1;
            w_grant_cnt_nxt = r_grant_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == 8'd0) begin
            w_state_nxt  = S_IDLE;
            w_onehot_nxt = '0;
            w_valid_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_onehot_nxt = '0;
          w_valid_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_onehot = r_onehot;
  assign out_valid  = r_valid;
  assign grant_cnt  = r_grant_cnt;

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// Bench for onehot_grant_decoder: a HOLD=3 and a HOLD=1 instance share stimulus
// and are compared against a cycles-remaining reference model plus fixed vectors.
module tb_onehot_grant_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       flush;
  logic [1:0] in_code;

  logic       rdy3, v3, rdy1, v1;
  logic [3:0] oh3, oh1;
  logic [7:0] gc3, gc1;

  int tests = 0;
  int fails = 0;

  int m_left[2];
  int m_code[2];
  int m_gc[2];
  int m_hold[2] = '{3, 1};

  always #5 clk = ~clk;

  onehot_grant_decoder #(.IN_W(2), .HOLD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
    .in_ready(rdy3), .flush(flush), .out_onehot(oh3), .out_valid(v3),
    .grant_cnt(gc3)
  );

  onehot_grant_decoder #(.IN_W(2), .HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_valid(in_valid),
    .in_ready(rdy1), .flush(flush), .out_onehot(oh1), .out_valid(v1),
    .grant_cnt(gc1)
  );

  typedef struct {
    logic       v;
    logic [1:0] c;
    logic       f;
    logic [3:0] oh;
    logic       rdy;
    logic [7:0] gc;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0;
      m_code[i] = 0;
      m_gc[i]   = 0;
    end
  endtask

  // Model tracks only how many grant cycles remain; zero means idle.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (flush) m_left[i] = 0;
      else if (m_left[i] == 0 && in_valid) begin
        m_left[i] = m_hold[i];
        m_code[i] = int'(in_code);
        m_gc[i]   = (m_gc[i] + 1) % 256;
      end else if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
    end
  endtask

  function automatic logic [31:0] model_exp(input int i);
    logic [3:0] oh;
    oh = (m_left[i] > 0) ? 4'(1 << m_code[i]) : 4'd0;
    return {18'd0, (m_left[i] == 0), (m_left[i] > 0), oh, 8'(m_gc[i])};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #2;
    chk("model_h3", {18'd0, rdy3, v3, oh3, gc3}, model_exp(0));
    chk("model_h1", {18'd0, rdy1, v1, oh1, gc1}, model_exp(1));
  endtask

  initial begin
    tbl = '{
      '{1, 0, 0, 4'b0001, 0, 1}, '{1, 1, 0, 4'b0001, 0, 1}, '{1, 1, 0, 4'b0001, 0, 1},
      '{1, 1, 0, 4'b0000, 1, 1}, '{1, 1, 0, 4'b0010, 0, 2}, '{1, 2, 0, 4'b0010, 0, 2},
      '{1, 2, 0, 4'b0010, 0, 2}, '{1, 2, 0, 4'b0000, 1, 2}, '{1, 2, 0, 4'b0100, 0, 3},
      '{1, 3, 0, 4'b0100, 0, 3}, '{1, 3, 0, 4'b0100, 0, 3}, '{1, 3, 0, 4'b0000, 1, 3},
      '{1, 3, 0, 4'b1000, 0, 4}, '{0, 3, 0, 4'b1000, 0, 4}, '{0, 0, 0, 4'b1000, 0, 4},
      '{0, 0, 0, 4'b0000, 1, 4}, '{1, 1, 0, 4'b0010, 0, 5}, '{0, 0, 0, 4'b0010, 0, 5},
      '{0, 0, 1, 4'b0000, 1, 5}, '{1, 3, 1, 4'b0000, 1, 5}, '{0, 0, 0, 4'b0000, 1, 5}
    };

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_code = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_h3", {22'd0, v3, oh3, gc3}, 32'd0);
    chk("reset_h1", {22'd0, v1, oh1, gc1}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {30'd0, rdy3, rdy1}, 32'd3);

    // Sweep, backpressure and flush vectors for the HOLD=3 instance.
    for (int i = 0; i < 21; i++) begin
      in_valid = tbl[i].v;
      in_code  = tbl[i].c;
      flush    = tbl[i].f;
      cyc();
      chk($sformatf("vec%0d", i), {18'd0, oh3, v3, rdy3, gc3},
          {18'd0, tbl[i].oh, |tbl[i].oh, tbl[i].rdy, tbl[i].gc});
    end

    // HOLD=1 with continuous valid alternates grant and idle cycles.
    in_valid = 1'b1; in_code = 2'd1; flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("h1_alt%0d", i), {27'd0, v1, oh1},
          (i % 2 == 0) ? 32'h12 : 32'h0);
    end

    // Asynchronous reset while a code-2 grant is being held.
    in_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b1; in_code = 2'd2;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("pre_reset_grant", {28'd0, oh3}, 32'h4);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midhold_reset_h3", {22'd0, v3, oh3, gc3}, 32'd0);
    chk("midhold_reset_h1", {22'd0, v1, oh1, gc1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_midhold_reset", {30'd0, rdy3, rdy1}, 32'd3);

    // Wrap: 256 accepts in 512 cycles on the HOLD=1 instance.
    in_valid = 1'b1;
    for (int i = 0; i < 512; i++) begin
      in_code = 2'($urandom_range(0, 3));
      cyc();
    end
    chk("wrap_256", {24'd0, gc1}, 32'd0);
    cyc();
    chk("wrap_257", {24'd0, gc1}, 32'd1);

    // Randomised traffic with flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 9) == 0);
      in_code  = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
